// File: rtl/vga_fade_out.sv
// Final video stage: expands 3-3-2 pixels to 4-4-4, blanks outside the visible area,
// delay-aligns the syncs with the pixel and applies a frame-synchronous fade.
module vga_fade_out #(
  parameter int FADE_LOG2       = 3,
  parameter int FRAMES_PER_STEP = 4,
  parameter int PIPE_DELAY      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] RGB_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       blank_in,
  input  logic       display_on,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       hsync,
  output logic       vsync,
  output logic       fade_busy
);

  localparam int LVL_W = FADE_LOG2 + 1;
  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(1) << FADE_LOG2;
  localparam logic [LVL_W-1:0] LVL_TOP  = LVL_MAX - LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

  typedef enum logic [1:0] {
    BLACK    = 2'd0,
    FADE_IN  = 2'd1,
    ON       = 2'd2,
    FADE_OUT = 2'd3
  } state_t;

  state_t           state;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] frame_cnt;
  logic             vsync_prev;
  logic             frame_tick;

  logic             hs_d;
  logic             vs_d;
  logic             bl_d;

  logic [3:0]       r4;
  logic [3:0]       g4;
  logic [3:0]       b4;

  // The mux has already registered the pixel, so sync/blank need PIPE_DELAY extra stages.
  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign hs_d = hsync_in;
      assign vs_d = vsync_in;
      assign bl_d = blank_in;
    end else begin : g_delay
      logic [PIPE_DELAY-1:0] hs_sr;
      logic [PIPE_DELAY-1:0] vs_sr;
      logic [PIPE_DELAY-1:0] bl_sr;

      always_ff @(posedge clk) begin
        if (reset) begin
          hs_sr <= '1;
          vs_sr <= '1;
          bl_sr <= '0;
        end else begin
          hs_sr[0] <= hsync_in;
          vs_sr[0] <= vsync_in;
          bl_sr[0] <= blank_in;
          for (int i = 1; i < PIPE_DELAY; i++) begin
            hs_sr[i] <= hs_sr[i-1];
            vs_sr[i] <= vs_sr[i-1];
            bl_sr[i] <= bl_sr[i-1];
          end
        end
      end

      assign hs_d = hs_sr[PIPE_DELAY-1];
      assign vs_d = vs_sr[PIPE_DELAY-1];
      assign bl_d = bl_sr[PIPE_DELAY-1];
    end
  endgenerate

  assign r4 = {RGB_in[7:5], RGB_in[7]};
  assign g4 = {RGB_in[4:2], RGB_in[4]};
  assign b4 = {RGB_in[1:0], RGB_in[1:0]};

  // Truncating multiply: level == LVL_MAX reproduces the channel exactly.
  function automatic logic [3:0] scale(input logic [3:0] ch, input logic [LVL_W-1:0] lvl);
    logic [LVL_W+3:0] prod;
    prod = {{LVL_W{1'b0}}, ch} * {4'b0000, lvl};
    return prod[FADE_LOG2 +: 4];
  endfunction

  assign frame_tick = vsync_in & ~vsync_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      hsync <= hs_d;
      vsync <= vs_d;
      if (bl_d) begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end else begin
        red   <= scale(r4, level);
        green <= scale(g4, level);
        blue  <= scale(b4, level);
      end
    end
  end

  // Fade controller only moves on a frame tick, so the picture never changes mid-frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BLACK;
      level      <= '0;
      frame_cnt  <= '0;
      fade_busy  <= 1'b0;
      vsync_prev <= 1'b1;
    end else begin
      vsync_prev <= vsync_in;
      if (frame_tick) begin
        case (state)
          BLACK: begin
            if (display_on) begin
              state     <= FADE_IN;
              frame_cnt <= '0;
              fade_busy <= 1'b1;
            end
          end
          FADE_IN: begin
            if (!display_on) begin
              state     <= FADE_OUT;
              frame_cnt <= '0;
            end else if (frame_cnt == CNT_LAST) begin
              frame_cnt <= '0;
              level     <= level + LVL_ONE;
              if (level == LVL_TOP) begin
                state     <= ON;
                fade_busy <= 1'b0;
              end
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
          ON: begin
            if (!display_on) begin
              state     <= FADE_OUT;
              frame_cnt <= '0;
              fade_busy <= 1'b1;
            end
          end
          FADE_OUT: begin
            if (display_on) begin
              state     <= FADE_IN;
              frame_cnt <= '0;
            end else if (frame_cnt == CNT_LAST) begin
              frame_cnt <= '0;
              level     <= level - LVL_ONE;
              if (level == LVL_ONE) begin
                state     <= BLACK;
                fade_busy <= 1'b0;
              end
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
          default: begin
            state     <= BLACK;
            level     <= '0;
            frame_cnt <= '0;
            fade_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_fade_out.sv
// Self-checking bench for vga_fade_out: reset, fade ramps, colour expansion table,
// sync/blank alignment, fade reversal and display_on toggling between ticks.
module tb_vga_fade_out;

  localparam int FPS  = 4;
  localparam int LMAX = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] RGB_in;
  logic       hsync_in;
  logic       vsync_in;
  logic       blank_in;
  logic       display_on;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       hsync;
  logic       vsync;
  logic       fade_busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  rgb;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t        vecs[7];
  logic [11:0] sb_exp[$];
  int          sb_idx[$];

  vga_fade_out #(
    .FADE_LOG2(3),
    .FRAMES_PER_STEP(FPS),
    .PIPE_DELAY(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .RGB_in(RGB_in),
    .hsync_in(hsync_in),
    .vsync_in(vsync_in),
    .blank_in(blank_in),
    .display_on(display_on),
    .red(red),
    .green(green),
    .blue(blue),
    .hsync(hsync),
    .vsync(vsync),
    .fade_busy(fade_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Full-white input scaled by lvl/8, truncated, on all three channels.
  function automatic logic [11:0] expColour(input int lvl);
    int c;
    c = (15 * lvl) / LMAX;
    return {c[3:0], c[3:0], c[3:0]};
  endfunction

  // One frame boundary; optionally pulses display_on low while vsync is low.
  task automatic frameTick(input bit toggle);
    @(negedge clk) vsync_in = 1'b0;
    if (toggle) display_on = ~display_on;
    @(negedge clk);
    if (toggle) display_on = ~display_on;
    @(negedge clk) vsync_in = 1'b1;
    @(negedge clk);
  endtask

  task automatic checkLevel(input int lvl, input bit busy, input string tag);
    @(negedge clk);
    checkOutput({tag, " rgb"}, {20'd0, red, green, blue}, {20'd0, expColour(lvl)});
    checkOutput({tag, " busy"}, {31'd0, fade_busy}, {31'd0, busy});
  endtask

  task automatic runTicks(input int n, input int start_lvl, input int dir, input bit toggle,
                          input string tag);
    for (int k = 1; k <= n; k++) begin
      int lvl;
      frameTick(toggle);
      lvl = start_lvl + dir * (k / FPS);
      checkLevel(lvl, (dir > 0) ? (lvl < LMAX) : (lvl > 0), $sformatf("%s t%0d", tag, k));
    end
  endtask

  task automatic applyStimulus(input int idx);
    RGB_in = vecs[idx].rgb;
    sb_exp.push_back(vecs[idx].exp_rgb);
    sb_idx.push_back(idx);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " rgb"}, {20'd0, red, green, blue}, 32'd0);
    checkOutput({tag, " hsync"}, {31'd0, hsync}, 32'd1);
    checkOutput({tag, " vsync"}, {31'd0, vsync}, 32'd1);
    checkOutput({tag, " busy"}, {31'd0, fade_busy}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'b101_010_01, 12'hB45};
    vecs[1] = '{8'h00,         12'h000};
    vecs[2] = '{8'hFF,         12'hFFF};
    vecs[3] = '{8'b100_100_10, 12'h99A};
    vecs[4] = '{8'b011_001_11, 12'h62F};
    vecs[5] = '{8'b111_000_00, 12'hF00};
    vecs[6] = '{8'b010_111_01, 12'h4F5};

    reset      = 1'b1;
    RGB_in     = 8'hFF;
    hsync_in   = 1'b1;
    vsync_in   = 1'b1;
    blank_in   = 1'b0;
    display_on = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("power-on reset");
    reset = 1'b0;

    $display("[TB] BLACK holds while display_on=0");
    frameTick(0);
    checkLevel(0, 0, "black hold");

    $display("[TB] fade in from BLACK");
    display_on = 1'b1;
    frameTick(0);
    checkLevel(0, 1, "enter fade_in");
    runTicks(16, 0, 1, 0, "fade_in lo");
    runTicks(16, 4, 1, 0, "fade_in hi");

    $display("[TB] colour expansion table at full level");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(i);
      @(negedge clk);
      if (sb_exp.size() == 0) begin
        checkOutput("scoreboard underflow", 32'd0, 32'd1);
      end else begin
        logic [11:0] e;
        int          n;
        e = sb_exp.pop_front();
        n = sb_idx.pop_front();
        checkOutput($sformatf("colour vec%0d", n), {20'd0, red, green, blue}, {20'd0, e});
      end
    end
    RGB_in = 8'hFF;
    @(negedge clk);

    $display("[TB] sync/blank alignment");
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    blank_in = 1'b1;
    @(negedge clk);
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    blank_in = 1'b0;
    checkOutput("align +1 hsync", {31'd0, hsync}, 32'd1);
    checkOutput("align +1 rgb", {20'd0, red, green, blue}, 32'hFFF);
    @(negedge clk);
    checkOutput("align +2 hsync", {31'd0, hsync}, 32'd0);
    checkOutput("align +2 vsync", {31'd0, vsync}, 32'd0);
    checkOutput("align +2 rgb", {20'd0, red, green, blue}, 32'h000);
    @(negedge clk);
    checkOutput("align +3 hsync", {31'd0, hsync}, 32'd1);
    checkOutput("align +3 vsync", {31'd0, vsync}, 32'd1);
    checkOutput("align +3 rgb", {20'd0, red, green, blue}, 32'hFFF);
    checkOutput("align busy", {31'd0, fade_busy}, 32'd0);

    $display("[TB] fade out to level 5, reverse twice");
    display_on = 1'b0;
    frameTick(0);
    checkLevel(8, 1, "enter fade_out");
    runTicks(12, 8, -1, 0, "fade_out");
    display_on = 1'b1;
    frameTick(0);
    checkLevel(5, 1, "reverse to in");
    display_on = 1'b0;
    frameTick(0);
    checkLevel(5, 1, "reverse to out");
    runTicks(4, 5, -1, 0, "after reverse");
    runTicks(16, 4, -1, 0, "down to black");

    $display("[TB] display_on toggling between ticks");
    display_on = 1'b1;
    frameTick(1);
    checkLevel(0, 1, "toggle enter");
    runTicks(32, 0, 1, 1, "toggle fade");

    $display("[TB] reset mid-fade at level 5");
    display_on = 1'b0;
    frameTick(0);
    checkLevel(8, 1, "pre-reset out");
    runTicks(12, 8, -1, 0, "pre-reset");
    reset = 1'b1;
    @(negedge clk);
    checkReset("mid-fade reset c1");
    repeat (2) @(negedge clk);
    checkReset("mid-fade reset c3");
    reset = 1'b0;
    frameTick(0);
    checkLevel(0, 0, "post-reset hold");
    display_on = 1'b1;
    frameTick(0);
    checkLevel(0, 1, "post-reset enter");
    runTicks(4, 0, 1, 0, "post-reset fade");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
